// File: rtl/exu_chn_arb_pkg.sv
// exu_chn_arb shared types.
// chn_idx_t is sized for the widest supported channel count.
package exu_arb_pkg;

  localparam int unsigned ARB_CHN_MAX = 8;

  typedef logic [$clog2(ARB_CHN_MAX)-1:0] chn_idx_t;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/exu_chn_arb_if.sv
// GPR-port arbitration bundle between exec channels and exu_chn_arb.
// master = channel side, slave = arbiter side.
interface exu_chn_arb_if #(
  parameter int unsigned CHN_NUM = 2
);

  localparam int unsigned IW = $clog2(CHN_NUM);

  logic [CHN_NUM-1:0] req;
  logic [CHN_NUM-1:0] done;
  logic               err_clr;
  logic [CHN_NUM-1:0] chn_sels;
  logic               busy;
  logic [IW-1:0]      gnt_idx;
  logic               hold_err;

  modport master (
    output req, done, err_clr,
    input  chn_sels, busy, gnt_idx, hold_err
  );

  modport slave (
    input  req, done, err_clr,
    output chn_sels, busy, gnt_idx, hold_err
  );

endinterface

// File: rtl/exu_chn_arb_pick.sv
// Combinational round-robin picker: first requester at or
// after i_ptr, searching upward modulo CHN_NUM.
module exu_rr_pick #(
  parameter int unsigned CHN_NUM = 2
) (
  input  logic [CHN_NUM-1:0]         i_req,
  input  logic [$clog2(CHN_NUM)-1:0] i_ptr,
  output logic                       o_any,
  output logic [$clog2(CHN_NUM)-1:0] o_idx
);

  localparam int unsigned IW = $clog2(CHN_NUM);

  function automatic logic [IW-1:0] cand(
    input logic [IW-1:0] p,
    input int             k
  );
    return IW'((int'(p) + k) % int'(CHN_NUM));
  endfunction

  // Walk from the far end so the nearest hit is written last.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int k = CHN_NUM - 1; k >= 0; k--) begin
      if (i_req[cand(i_ptr, k)]) begin
        o_any = 1'b1;
        o_idx = cand(i_ptr, k);
      end
    end
  end

endmodule

// File: rtl/exu_chn_arb.sv
// Round-robin owner of the shared EXU GPR ports; registered
// one-hot chn_sels plus a sticky hold-time watchdog.
module exu_chn_arb
  import exu_arb_pkg::*;
#(
  parameter int unsigned CHN_NUM  = 2,
  parameter int unsigned HOLD_MAX = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  exu_chn_arb_if.slave bus
);

  localparam int unsigned IW = $clog2(CHN_NUM);
  localparam int unsigned CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(HOLD_MAX);
  localparam logic [CW-1:0] CNT_PRE  = CW'(HOLD_MAX - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(CHN_NUM - 1);

  arb_state_e         r_state;
  logic [CHN_NUM-1:0] r_sels;
  logic [IW-1:0]      r_idx;
  logic [IW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;
  logic               r_hit;
  logic               r_err;

  logic               w_grant;
  logic               w_rel;
  logic               w_inc;
  logic               w_any;
  logic [IW-1:0]      w_nxt_ptr;
  logic [IW-1:0]      w_pick_ptr;
  logic [IW-1:0]      w_idx;

  assign w_grant    = (r_state == ARB_GRANT);
  assign w_rel      = w_grant & bus.done[r_idx];
  assign w_inc      = w_grant & ~w_rel & (r_cnt != CNT_MAX);
  assign w_nxt_ptr  = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
  // On release, arbitrate from the post-release pointer.
  assign w_pick_ptr = w_grant ? w_nxt_ptr : r_ptr;

  exu_rr_pick #(
    .CHN_NUM (CHN_NUM)
  ) u_pick (
    .i_req (bus.req),
    .i_ptr (w_pick_ptr),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_sels  <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_hit   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // One-shot pulse on reaching HOLD_MAX keeps err_clr usable.
      r_hit <= w_inc & (r_cnt == CNT_PRE);
      if (r_hit) begin
        r_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_err <= 1'b0;
      end
      if (w_rel) begin
        r_ptr <= w_nxt_ptr;
      end
      if (!w_grant || w_rel) begin
        r_cnt <= '0;
        if (w_any) begin
          r_state <= ARB_GRANT;
          r_sels  <= {{(CHN_NUM-1){1'b0}}, 1'b1} << w_idx;
          r_idx   <= w_idx;
        end else begin
          r_state <= ARB_IDLE;
          r_sels  <= '0;
          r_idx   <= '0;
        end
      end else if (w_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.chn_sels = r_sels;
  assign bus.busy     = w_grant;
  assign bus.gnt_idx  = r_idx;
  assign bus.hold_err = r_err;

endmodule

// File: tb/tb_exu_chn_arb.sv
// Bench for exu_chn_arb: directed plan cases plus a random
// phase, all checked through a reference-model scoreboard.
module tb_exu_chn_arb;

  localparam int N = 4;
  localparam int H = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  exu_chn_arb_if #(.CHN_NUM(N)) bus();

  exu_chn_arb #(
    .CHN_NUM  (N),
    .HOLD_MAX (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] sels;
    logic         busy;
    logic [1:0]   idx;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   n_tot = 0;
  int   n_bad = 0;

  bit m_busy, m_err, m_hit;
  int m_idx, m_ptr, m_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr(input logic [N-1:0] r,
                            input int p,
                            output bit any);
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) begin
        any = 1'b1;
        return (p + k) % N;
      end
    end
    return 0;
  endfunction

  task automatic model_rst();
    m_busy = 0; m_err = 0; m_hit = 0;
    m_idx  = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r,
                            input logic [N-1:0] d,
                            input bit clr,
                            output exp_t e);
    bit rel, any;
    int pk;
    rel   = m_busy && d[m_idx];
    m_err = m_hit ? 1'b1 : (clr ? 1'b0 : m_err);
    m_hit = m_busy && !rel && (m_cnt == H - 1);
    if (m_busy && !rel) begin
      if (m_cnt < H) m_cnt++;
    end else begin
      if (rel) m_ptr = (m_idx + 1) % N;
      pk     = rr(r, m_ptr, any);
      m_busy = any;
      m_idx  = any ? pk : 0;
      m_cnt  = 0;
    end
    e      = '0;
    e.busy = m_busy;
    e.idx  = 2'(m_idx);
    e.err  = m_err;
    if (m_busy) e.sels[m_idx] = 1'b1;
  endtask

  task automatic cyc(input logic [N-1:0] r,
                     input logic [N-1:0] d,
                     input bit clr);
    exp_t e;
    bus.req     = r;
    bus.done    = d;
    bus.err_clr = clr;
    model_step(r, d, clr, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_sels", 32'(bus.chn_sels), 32'(e.sels));
    chk("sb_busy", 32'(bus.busy), 32'(e.busy));
    if (e.busy) chk("sb_idx", 32'(bus.gnt_idx), 32'(e.idx));
    chk("sb_err", 32'(bus.hold_err), 32'(e.err));
    chk("onehot0", 32'($onehot0(bus.chn_sels)), 32'd1);
  endtask

  initial begin
    logic [N-1:0] r, d;
    int cur;
    bus.req     = '0;
    bus.done    = '0;
    bus.err_clr = 1'b0;
    model_rst();

    // reset state
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sels", 32'(bus.chn_sels), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_idx", 32'(bus.gnt_idx), 32'd0);
    chk("rst_err", 32'(bus.hold_err), 32'd0);
    rst_n = 1'b1;

    // single request, release
    cyc(4'b0001, 4'b0000, 1'b0);
    chk("single_sels", 32'(bus.chn_sels), 32'h1);
    chk("single_busy", 32'(bus.busy), 32'd1);
    chk("single_idx", 32'(bus.gnt_idx), 32'd0);
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0001, 1'b0);
    chk("single_rel_sels", 32'(bus.chn_sels), 32'd0);
    chk("single_rel_busy", 32'(bus.busy), 32'd0);

    // contention: rr_ptr is 1 now, so grants run 1,0,1,0
    cyc(4'b0011, 4'b0000, 1'b0);
    chk("fair_first", 32'(bus.gnt_idx), 32'd1);
    cur = 1;
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0011, 4'b0001 << cur, 1'b0);
      cur = (k % 2 == 0) ? 0 : 1;
      chk("fair_idx", 32'(bus.gnt_idx), 32'(cur));
      chk("fair_nobubble", 32'(bus.busy), 32'd1);
    end
    cyc(4'b0000, 4'b0001, 1'b0);
    chk("fair_end_busy", 32'(bus.busy), 32'd0);

    // sticky grant
    cyc(4'b0010, 4'b0000, 1'b0);
    chk("sticky_gnt", 32'(bus.chn_sels), 32'h2);
    cyc(4'b0000, 4'b0001, 1'b0);
    chk("sticky_hold", 32'(bus.chn_sels), 32'h2);
    cyc(4'b0000, 4'b0000, 1'b0);
    chk("sticky_hold2", 32'(bus.chn_sels), 32'h2);
    cyc(4'b0000, 4'b0010, 1'b0);
    chk("sticky_rel", 32'(bus.chn_sels), 32'h0);

    // back-to-back with wrap from rr_ptr=2
    cyc(4'b0010, 4'b0000, 1'b0);
    chk("b2b_first", 32'(bus.gnt_idx), 32'd1);
    cyc(4'b0011, 4'b0010, 1'b0);
    chk("b2b_idx", 32'(bus.gnt_idx), 32'd0);
    chk("b2b_sels", 32'(bus.chn_sels), 32'h1);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    cyc(4'b0000, 4'b0001, 1'b0);

    // watchdog
    cyc(4'b0001, 4'b0000, 1'b0);
    chk("wd_gnt", 32'(bus.chn_sels), 32'h1);
    for (int k = 1; k <= 5; k++) begin
      cyc(4'b0000, 4'b0000, 1'b0);
      chk("wd_err", 32'(bus.hold_err), 32'(k == 5));
    end
    cyc(4'b0000, 4'b0000, 1'b0);
    chk("wd_sticky", 32'(bus.hold_err), 32'd1);
    cyc(4'b0000, 4'b0000, 1'b1);
    chk("wd_clr", 32'(bus.hold_err), 32'd0);
    chk("wd_keep", 32'(bus.chn_sels), 32'h1);

    // set beats err_clr in the same cycle
    cyc(4'b0000, 4'b0001, 1'b0);
    cyc(4'b0001, 4'b0000, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      cyc(4'b0000, 4'b0000, 1'b1);
    end
    chk("wd_set_wins", 32'(bus.hold_err), 32'd1);
    cyc(4'b0000, 4'b0000, 1'b0);

    // async reset mid-grant, between edges
    bus.req = 4'b0010;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sels", 32'(bus.chn_sels), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_err", 32'(bus.hold_err), 32'd0);
    model_rst();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(4'b0010, 4'b0000, 1'b0);
    chk("arst_regrant", 32'(bus.chn_sels), 32'h2);
    cyc(4'b0000, 4'b0010, 1'b0);

    // random traffic against the model
    for (int k = 0; k < 300; k++) begin
      r = 4'($urandom);
      if (m_busy && ($urandom_range(0, 2) == 0))
        d = 4'b0001 << m_idx;
      else
        d = 4'($urandom) & 4'($urandom);
      cyc(r, d, $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/exu_chn_arb.md
Name: exu_chn_arb

Overview:
- Round-robin arbiter that owns the shared EXU GPR read/write ports. It generates the one-hot `chn_sels` vector consumed by exu_gpr_rw_mux, so it sits directly upstream of that mux.
- Each execution channel requests the GPR ports and holds its grant until it signals completion. Grants are registered, so `chn_sels` is glitch-free.
- A hold-time watchdog flags a channel that never completes.

Parameters:
- CHN_NUM, 2, number of execution channels (range 2..8).
- HOLD_MAX, 64, maximum number of cycles one grant may be held before the watchdog fires (range 1..65535).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- req[CHN_NUM]  input  1 each  channel i requests the GPR ports; level-sensitive.
- done[CHN_NUM]  input  1 each  channel i finishes its access this cycle; single-cycle pulse.
- chn_sels[CHN_NUM]  output  1 each  registered one-hot grant (or all-zero); drives exu_gpr_rw_mux.
- busy  output  1  a grant is currently held.
- gnt_idx  output  $clog2(CHN_NUM)  index of the granted channel; valid only while busy.
- hold_err  output  1  sticky watchdog error.
- err_clr  input  1  clears hold_err.

Behaviour:
- Reset (async assert, sync deassert handled outside the block):
  - chn_sels all 0, busy 0, gnt_idx 0, hold_err 0.
  - Round-robin pointer rr_ptr = 0; hold counter = 0; state IDLE.
- The state machine has two states, IDLE and GRANT.
- IDLE:
  - If any req[i] is 1, select the first requesting index at or after rr_ptr, searching upward modulo CHN_NUM.
  - Next cycle: chn_sels[sel]=1, busy=1, gnt_idx=sel, state GRANT, hold counter = 0.
  - Request-to-grant latency is exactly 1 cycle. With no requests, stay in IDLE with all outputs zero.
- GRANT:
  - The grant is held regardless of req; deassertion of req by the granted channel is ignored.
  - done[j] where j != gnt_idx is ignored.
  - done[gnt_idx]=1 releases the grant and sets rr_ptr = (gnt_idx+1) mod CHN_NUM. In the same cycle, arbitrate among the current req vector using the new rr_ptr:
    - If a request exists, the next cycle grants it directly, with no idle bubble. The same channel may be re-granted if it is the only requester.
    - If no request exists, the next cycle goes to IDLE with chn_sels all 0.
- Watchdog:
  - The hold counter increments every GRANT cycle without done[gnt_idx] and saturates at HOLD_MAX.
  - When the counter reaches HOLD_MAX, hold_err is set on the next cycle.
  - The grant is NOT revoked; recovery is left to software/reset.
  - err_clr clears hold_err. If err_clr and a set condition occur in the same cycle, set wins.
- Invariants:
  - chn_sels is never multi-hot.
  - chn_sels is never changed mid-grant except on done.
- Reset mid-grant: all outputs return to reset values immediately (asynchronous); the pending done is lost.
- Counter width is $clog2(HOLD_MAX+1).

Decomposition:
- Shared package exu_arb_pkg: typedef chn_idx_t (width $clog2(CHN_NUM)) and the state enum {ARB_IDLE, ARB_GRANT}.
- One natural sub-module, exu_rr_pick: a combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: any, idx.
  - Reused for both the IDLE arbitration and the done-time arbitration.

Test Plan:
- Single request: reset, req[0]=1 at cycle 2 → chn_sels={1,0}, busy=1, gnt_idx=0 at cycle 3. Pulse done[0] at cycle 5 with req[0]=0 → chn_sels={0,0}, busy=0 at cycle 6.
- Contention fairness: req[0]=req[1]=1 held continuously, done pulsed in every GRANT cycle after the first → grants alternate 0,1,0,1 with no zero cycle between them.
- Sticky grant: grant channel 1, drop req[1], pulse done[0] → chn_sels stays {0,1} until done[1] arrives.
- Back-to-back: CHN_NUM=4, rr_ptr=2, req={1,1,0,0}, done on grant 1 → next grant is channel 0 in the following cycle (wrap-around search from ptr 2).
- Watchdog: HOLD_MAX=4, grant channel 0, never assert done → hold_err=1 on cycle 5 after the grant and stays 1. Assert err_clr → 0 next cycle; chn_sels still {1,0}.
- Async reset mid-grant: assert rst_n=0 between clock edges while granted → chn_sels, busy and hold_err go to 0 without waiting for a clock edge. After release with req[1]=1 → channel 1 is granted from rr_ptr=0.
